pdm_decimator: RTL and testbench

Receive-side counterpart of the 1-bit PDM DAC. The block takes a pulse-density-modulated bitstream on a single pin, such as a PDM microphone or a looped-back `pdm_dac` output. It recovers signed PCM samples with a 3rd-order CIC decimator and emits them with a one-cycle valid strobe. Its output feeds sample-domain logic such as mixers or recorders at `clk`/2^`OSR_LOG2` per bit-enable.

---
 rtl/pdm_decimator.sv | 99 +++++++++
 tb/tb_pdm_decimator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// pdm_decimator: 3rd-order CIC decimator that turns a 1-bit PDM stream into
// signed DATA_BITS-wide PCM samples with a single-cycle valid strobe.
module pdm_decimator #(
  parameter int OSR_LOG2  = 8,
  parameter int DATA_BITS = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pdm_in,
  input  logic                        bit_en,
  output logic signed [DATA_BITS-1:0] dout,
  output logic                        dout_valid
);
  localparam int W     = 3 * OSR_LOG2 + 1;
  localparam int SHIFT = W - 1 - DATA_BITS;
  localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;
  localparam logic signed [W:0] OFFSET  = {2'b00, 1'b1, {(W-2){1'b0}}};
  localparam logic signed [W:0] MAX_POS = {{(W+2-DATA_BITS){1'b0}}, {(DATA_BITS-1){1'b1}}};
  localparam logic signed [W:0] MIN_NEG = {{(W+2-DATA_BITS){1'b1}}, {(DATA_BITS-1){1'b0}}};

  logic                        sync_q1, sync_q2;
  logic [W-1:0]                int1, int2, int3, int3_next;
  logic [OSR_LOG2-1:0]         frame_cnt;
  logic                        dec;
  logic [W-1:0]                comb1, comb2, comb3;
  logic [W-1:0]                dly1, dly2, dly3;
  logic                        v1, v2, v3, v4;
  logic signed [W:0]           centered;
  logic signed [W:0]           scaled_q;
  logic signed [DATA_BITS-1:0] sat;

  assign int3_next = int3 + int2;
  assign dec       = bit_en && (frame_cnt == CNT_LAST);
  // Full-scale C3 is 2^(W-1), so one extra bit keeps it positive before centring.
  assign centered  = $signed({1'b0, comb3}) - OFFSET;

  always_comb begin
    sat = scaled_q[DATA_BITS-1:0];
    if (scaled_q > MAX_POS)
      sat = MAX_POS[DATA_BITS-1:0];
    else if (scaled_q < MIN_NEG)
      sat = MIN_NEG[DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      int1       <= '0;
      int2       <= '0;
      int3       <= '0;
      frame_cnt  <= '0;
      comb1      <= '0;
      comb2      <= '0;
      comb3      <= '0;
      dly1       <= '0;
      dly2       <= '0;
      dly3       <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      v4         <= 1'b0;
      scaled_q   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      sync_q1 <= pdm_in;
      sync_q2 <= sync_q1;
      if (bit_en) begin
        int1      <= int1 + W'(sync_q2);
        int2      <= int2 + int1;
        int3      <= int3_next;
        frame_cnt <= frame_cnt + OSR_LOG2'(1);
      end
      // Comb pipeline advances on the strobe chain, independent of bit_en gaps.
      v1         <= dec;
      v2         <= v1;
      v3         <= v2;
      v4         <= v3;
      dout_valid <= v4;
      if (dec) begin
        comb1 <= int3_next - dly1;
        dly1  <= int3_next;
      end
      if (v1) begin
        comb2 <= comb1 - dly2;
        dly2  <= comb1;
      end
      if (v2) begin
        comb3 <= comb2 - dly3;
        dly3  <= comb2;
      end
      if (v3)
        scaled_q <= centered >>> SHIFT;
      if (v4)
        dout <= sat;
    end
  end
endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: table-driven check of the PDM CIC decimator, with a
// first-order PDM DAC model for loopback and a mid-pipeline reset sequence.
module tb_pdm_decimator;
  localparam int OSR_LOG2  = 8;
  localparam int DATA_BITS = 12;
  localparam int R         = 1 << OSR_LOG2;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        pdm_in = 1'b0;
  logic                        bit_en = 1'b0;
  logic signed [DATA_BITS-1:0] dout;
  logic                        dout_valid;

  pdm_decimator #(.OSR_LOG2(OSR_LOG2), .DATA_BITS(DATA_BITS)) dut (
    .clk(clk),
    .reset(reset),
    .pdm_in(pdm_in),
    .bit_en(bit_en),
    .dout(dout),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  // mode: 0 = all zeros, 1 = all ones, 2 = alternating, 3 = DAC model of dac_val
  typedef struct {
    int mode;
    int dac_val;
    int en_period;
    int exp_dout;
    int tol;
  } vec_t;

  vec_t vecs[6];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   nbits = 0;
  int   dec_cyc = -1000;
  int   phase = 0;
  int   dac_acc = 0;
  int   mode = 0;
  int   dac_val = 0;
  int   en_period = 1;
  logic alt = 1'b0;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    n_vec++;
    if (act < exp - tol || act > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  // Drive one cycle of inputs, clock it, and track qualified bits / decimation edges.
  task automatic tick();
    logic en;
    en = (phase == 0);
    phase = (phase + 1 == en_period) ? 0 : phase + 1;
    case (mode)
      0: pdm_in = 1'b0;
      1: pdm_in = 1'b1;
      2: begin
        pdm_in = alt;
        alt = ~alt;
      end
      default: begin
        if (en) begin
          dac_acc += dac_val + 2048;
          if (dac_acc >= 4096) begin
            pdm_in = 1'b1;
            dac_acc -= 4096;
          end else begin
            pdm_in = 1'b0;
          end
        end
      end
    endcase
    bit_en = en;
    @(posedge clk);
    #1;
    cyc++;
    if (en && !reset) begin
      nbits++;
      if (nbits % R == 0) dec_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    int saved_mode;
    saved_mode = mode;
    mode = 2;
    en_period = 1;
    phase = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_dout", int'(dout), 0, 0);
      chk("rst_valid", int'(dout_valid), 0, 0);
    end
    reset = 1'b0;
    mode = saved_mode;
    nbits = 0;
    dec_cyc = -1000;
    phase = 0;
    dac_acc = 0;
    alt = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dout_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL strobe_timeout: no dout_valid within %0d cycles", budget);
    end
  endtask

  initial begin
    int at;
    int prev;
    int held;
    int d0;
    int rel_cyc;
    int nvalid;

    vecs[0] = '{1, 0,    1, 2047,  0};
    vecs[1] = '{0, 0,    1, -2048, 0};
    vecs[2] = '{2, 0,    1, 0,     0};
    vecs[3] = '{1, 0,    3, 2047,  0};
    vecs[4] = '{3, 1000, 1, 1000,  2};
    vecs[5] = '{3, -500, 1, -500,  2};

    for (int v = 0; v < 6; v++) begin
      mode = vecs[v].mode;
      do_reset();
      dac_val   = vecs[v].dac_val;
      en_period = vecs[v].en_period;
      prev = -1;
      for (int s = 1; s <= 6; s++) begin
        wait_strobe(2 * R * en_period + 50, at);
        if (at < 0) break;
        chk("latency", at - dec_cyc, 4, 0);
        if (prev >= 0) chk("spacing", at - prev, R * en_period, 0);
        prev = at;
        if (s >= 4) chk("dout", int'(dout), vecs[v].exp_dout, vecs[v].tol);
        if (s == 5) begin
          held = int'(dout);
          tick();
          chk("valid_pulse", int'(dout_valid), 0, 0);
          chk("hold", int'(dout), held, 0);
        end
      end
    end

    // Reset landing while a strobe is in flight must cancel it and restart the frame.
    mode = 1;
    do_reset();
    wait_strobe(2 * R + 50, at);
    d0 = dec_cyc;
    for (int i = 0; i < 2 * R && dec_cyc == d0; i++) tick();
    chk("mid_dec_seen", int'(dec_cyc != d0), 1, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", int'(dout_valid), 0, 0);
    chk("mid_rst_dout", int'(dout), 0, 0);
    reset = 1'b0;
    nbits = 0;
    dec_cyc = -1000;
    rel_cyc = cyc;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dout_valid) nvalid++;
    end
    chk("cancel", nvalid, 0, 0);
    wait_strobe(2 * R + 50, at);
    if (at >= 0) begin
      chk("restart_latency", at - dec_cyc, 4, 0);
      chk("restart_frame", at - rel_cyc, R + 4, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
